// File: rtl/wave_capture_ctrl.sv
// Arms on run/single, waits for a threshold crossing, writes 2**ADDR_W samples (registered, 1 cycle), then holds for frame ticks.
// No backpressure: adc_valid is the only qualifier. WAVE_AUTO_TRIG_EN adds a forced trigger after AUTO_TIMEOUT samples.
module wave_capture_ctrl #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 8,
    parameter int HOLDOFF_FRAMES = 2
`ifdef WAVE_AUTO_TRIG_EN
    ,
    parameter int AUTO_TIMEOUT   = 65535
`endif
) (
    input  logic              adc_clk,
    input  logic              rst_n,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              run,
    input  logic              single,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic              frame_tick,
    output logic              adc_buf_wr,
    output logic [11:0]       adc_buf_addr,
    output logic [DATA_W-1:0] adc_buf_data,
    output logic              capture_done,
    output logic              busy
);

    localparam int TW = $clog2(HOLDOFF_FRAMES + 1);

    typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, CAPTURE, HOLD} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] lvl_q, prev_q;
    logic              edge_q, prev_vld, single_mode, hold_entry;
    logic [ADDR_W-1:0] wr_cnt, addr_q, addr_nx;
    logic [TW-1:0]     tick_cnt;
    logic              wr_nx, done_nx, trig_hit, trig_any;

`ifdef WAVE_AUTO_TRIG_EN
    localparam int AW = $clog2(AUTO_TIMEOUT + 1);
    logic [AW-1:0] auto_cnt;
`endif

    // The first sample after ARM only seeds prev, so a crossing needs two valid samples.
    assign trig_hit = prev_vld && (trig_edge_sel(edge_q, prev_q, adc_data, lvl_q));

    function automatic logic trig_edge_sel(input logic fall, input logic [DATA_W-1:0] p,
                                           input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] l);
        return fall ? (p > l && c <= l) : (p < l && c >= l);
    endfunction

`ifdef WAVE_AUTO_TRIG_EN
    assign trig_any = trig_hit || (auto_cnt == AW'(AUTO_TIMEOUT));
`else
    assign trig_any = trig_hit;
`endif

    assign adc_buf_addr = 12'(addr_q);
    assign busy         = (state != IDLE);

    always_comb begin
        state_nx = state;
        wr_nx    = 1'b0;
        done_nx  = 1'b0;
        addr_nx  = addr_q;
        case (state)
            IDLE: begin
                if (run || single) state_nx = ARM;
            end
            ARM: begin
                state_nx = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                if (!run && !single_mode) begin
                    state_nx = IDLE;
                end else if (adc_valid && trig_any) begin
                    state_nx = CAPTURE;
                    wr_nx    = 1'b1;
                    addr_nx  = '0;
                end
            end
            CAPTURE: begin
                if (adc_valid) begin
                    wr_nx   = 1'b1;
                    addr_nx = wr_cnt;
                    if (wr_cnt == {ADDR_W{1'b1}}) begin
                        done_nx  = 1'b1;
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                if (frame_tick && !hold_entry && tick_cnt == TW'(HOLDOFF_FRAMES - 1))
                    state_nx = run ? ARM : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            adc_buf_wr   <= 1'b0;
            addr_q       <= '0;
            adc_buf_data <= '0;
            capture_done <= 1'b0;
            lvl_q        <= '0;
            edge_q       <= 1'b0;
            prev_q       <= '0;
            prev_vld     <= 1'b0;
            single_mode  <= 1'b0;
            hold_entry   <= 1'b0;
            wr_cnt       <= '0;
            tick_cnt     <= '0;
`ifdef WAVE_AUTO_TRIG_EN
            auto_cnt     <= '0;
`endif
        end else begin
            state        <= state_nx;
            adc_buf_wr   <= wr_nx;
            capture_done <= done_nx;
            addr_q       <= addr_nx;
            if (wr_nx) adc_buf_data <= adc_data;

            case (state)
                IDLE: single_mode <= !run;
                ARM: begin
                    lvl_q    <= trig_level;
                    edge_q   <= trig_edge;
                    prev_vld <= 1'b0;
`ifdef WAVE_AUTO_TRIG_EN
                    auto_cnt <= '0;
`endif
                end
                WAIT_TRIG: begin
                    wr_cnt <= ADDR_W'(1);
                    if (adc_valid) begin
                        prev_q   <= adc_data;
                        prev_vld <= 1'b1;
`ifdef WAVE_AUTO_TRIG_EN
                        auto_cnt <= auto_cnt + 1'b1;
`endif
                    end
                end
                CAPTURE: begin
                    if (adc_valid) wr_cnt <= wr_cnt + 1'b1;
                end
                HOLD: begin
                    hold_entry <= 1'b0;
                    if (frame_tick && !hold_entry) tick_cnt <= tick_cnt + 1'b1;
                end
                default: ;
            endcase

            // A tick landing on the first HOLD cycle belongs to the frame already being shown.
            if (state != HOLD && state_nx == HOLD) begin
                hold_entry <= 1'b1;
                tick_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Scoreboard bench for wave_capture_ctrl: a reference trigger/capture model queues expected writes, a negedge monitor pops them.
module tb_wave_capture_ctrl;

    localparam int N = 1024;

    logic        adc_clk = 1'b0;
    logic        rst_n, adc_valid, run, single, trig_edge, frame_tick;
    logic [7:0]  adc_data, trig_level;
    logic        adc_buf_wr, capture_done, busy;
    logic [11:0] adc_buf_addr;
    logic [7:0]  adc_buf_data;

    always #5 adc_clk = ~adc_clk;

    wave_capture_ctrl #(
        .ADDR_W(10), .DATA_W(8), .HOLDOFF_FRAMES(2)
`ifdef WAVE_AUTO_TRIG_EN
        , .AUTO_TIMEOUT(16)
`endif
    ) dut (
        .adc_clk(adc_clk), .rst_n(rst_n), .adc_valid(adc_valid), .adc_data(adc_data),
        .run(run), .single(single), .trig_level(trig_level), .trig_edge(trig_edge),
        .frame_tick(frame_tick), .adc_buf_wr(adc_buf_wr), .adc_buf_addr(adc_buf_addr),
        .adc_buf_data(adc_buf_data), .capture_done(capture_done), .busy(busy)
    );

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_bad = 0, n_wr = 0, n_done = 0, base_wr, base_done;

    int         m_phase = 0, m_addr = 0, m_auto = 0;
    bit         m_prev_vld = 0, m_edge = 0;
    logic [7:0] m_prev = 0, m_lvl = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge adc_clk) begin
        if (adc_buf_wr) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("unexpected_wr_pending", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", adc_buf_addr, e.addr);
                chk("wr_data", adc_buf_data, e.data);
                chk("wr_done", capture_done, e.done);
            end
        end else if (capture_done) begin
            chk("done_without_wr", capture_done, adc_buf_wr);
        end
        if (capture_done) n_done++;
    end

    task automatic push_exp(input int a, input logic [7:0] d, input bit dn);
        exp_t e;
        e.addr = 12'(a);
        e.data = d;
        e.done = dn;
        exp_q.push_back(e);
    endtask

    task automatic arm_model(input logic [7:0] lvl, input bit edg);
        m_phase = 1; m_prev_vld = 0; m_lvl = lvl; m_edge = edg; m_auto = 0;
    endtask

    task automatic model_step(input logic [7:0] d);
        bit hit;
        if (m_phase == 1) begin
            hit = m_prev_vld && (m_edge ? (m_prev > m_lvl && d <= m_lvl)
                                        : (m_prev < m_lvl && d >= m_lvl));
`ifdef WAVE_AUTO_TRIG_EN
            if (m_auto == 16) hit = 1;
            m_auto++;
`endif
            if (hit) begin
                push_exp(0, d, 0);
                m_phase = 2;
                m_addr  = 1;
            end
            m_prev = d; m_prev_vld = 1;
        end else if (m_phase == 2) begin
            push_exp(m_addr, d, m_addr == N - 1);
            if (m_addr == N - 1) m_phase = 0;
            else m_addr++;
        end
    endtask

    task automatic sample(input bit v, input logic [7:0] d);
        adc_valid = v;
        adc_data  = d;
        if (v) model_step(d);
        @(posedge adc_clk); #1;
        adc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) sample(1'b0, 8'd0);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge adc_clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wr"},   adc_buf_wr,   0);
        chk({tag, "_addr"}, adc_buf_addr, 0);
        chk({tag, "_data"}, adc_buf_data, 0);
        chk({tag, "_done"}, capture_done, 0);
        chk({tag, "_busy"}, busy,         0);
    endtask

    initial begin
        rst_n = 0; adc_valid = 0; adc_data = 0; run = 0; single = 0;
        trig_level = 0; trig_edge = 0; frame_tick = 0;
        repeat (3) @(posedge adc_clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1;
        idle(2);
        chk("idle_busy", busy, 0);

        // Continuous rising trigger at 128 on a wrapping ramp
        trig_level = 8'd128; trig_edge = 0; run = 1;
        base_wr = n_wr; base_done = n_done;
        idle(4);
        arm_model(8'd128, 0);
        for (int i = 0; i < 1300; i++) sample(1'b1, 8'(i));
        idle(2);
        chk("ramp_writes", n_wr - base_wr, N);
        chk("ramp_done_pulses", n_done - base_done, 1);
        chk("ramp_hold_busy", busy, 1);

        // Re-arm after two ticks; threshold moved after ARM must be ignored; gapped valid; reset at addr 500
        tick(); tick();
        idle(2);
        trig_level = 8'd110;
        arm_model(8'd128, 0);
        for (int k = 0; k < 2000 && !(m_phase == 2 && m_addr == 501); k++) begin
            sample(1'b1, 8'(100 + k));
            if (!(m_phase == 2 && m_addr == 501)) idle(2);
        end
        run   = 0;
        rst_n = 0;
        m_phase = 0;
        @(posedge adc_clk); #1;
        chk_outputs_zero("midreset");
        chk("midreset_sb_empty", exp_q.size(), 0);
        rst_n = 1;
        idle(2);

        // Single shot, falling edge at 100; second single during capture is ignored; holdoff timing
        trig_edge = 1; trig_level = 8'd100;
        base_wr = n_wr; base_done = n_done;
        single = 1; @(posedge adc_clk); #1; single = 0;
        idle(3);
        arm_model(8'd100, 1);
        sample(1'b1, 8'd90);
        sample(1'b1, 8'd120);
        sample(1'b1, 8'd110);
        idle(1);
        chk("fall_no_early_wr", n_wr - base_wr, 0);
        sample(1'b1, 8'd100);
        for (int i = 1; i < N; i++) begin
            single = (i == 300);
            sample(1'b1, 8'(i * 7));
        end
        single = 0;
        tick();
        chk("hold_entry_tick_busy", busy, 1);
        idle(2);
        tick();
        chk("hold_one_tick_busy", busy, 1);
        idle(2);
        tick();
        chk("hold_two_ticks_idle", busy, 0);
        for (int i = 0; i < 20; i++) sample(1'b1, (i % 2) ? 8'd100 : 8'd120);
        idle(2);
        chk("single_writes", n_wr - base_wr, N);
        chk("single_done_pulses", n_done - base_done, 1);
        chk("single_stays_idle", busy, 0);

        // Constant zero input: no trigger unless auto-trigger is built in
        trig_edge = 0; trig_level = 8'd128; run = 1;
        base_wr = n_wr;
        idle(4);
        arm_model(8'd128, 0);
        for (int i = 0; i < 10000; i++) sample(1'b1, 8'd0);
        idle(2);
`ifdef WAVE_AUTO_TRIG_EN
        chk("const_zero_writes", n_wr - base_wr, N);
`else
        chk("const_zero_writes", n_wr - base_wr, 0);
        chk("const_zero_busy", busy, 1);
`endif
        run = 0;
        idle(2);
        tick(); idle(1); tick(); idle(1); tick(); idle(2);
        chk("final_idle", busy, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
